// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: encoding modes, fixed symbols, the TERC4 lookup and the
// 8b/9b transition-minimisation helpers.
package tmds_pkg;

  typedef enum logic [2:0] {
    MODE_CTRL   = 3'd0,
    MODE_VIDEO  = 3'd1,
    MODE_VGUARD = 3'd2,
    MODE_TERC4  = 3'd3,
    MODE_DGUARD = 3'd4
  } tmds_mode_t;

  localparam logic [9:0] CTRL_SYM_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_SYM_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_SYM_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_SYM_11 = 10'b1010101011;

  localparam logic [9:0] GUARD_SYM_A = 10'b1011001100;
  localparam logic [9:0] GUARD_SYM_B = 10'b0100110011;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    unique case (c)
      2'b00:   s = CTRL_SYM_00;
      2'b01:   s = CTRL_SYM_01;
      2'b10:   s = CTRL_SYM_10;
      default: s = CTRL_SYM_11;
    endcase
    return s;
  endfunction

  function automatic logic [9:0] terc4_sym(input logic [3:0] nib);
    logic [9:0] s;
    unique case (nib)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(d[i]);
    end
    return n;
  endfunction

  // q[8] = 1 marks XOR chaining, 0 marks XNOR chaining.
  function automatic logic [8:0] tm_minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = popcount8(d);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 minimises transitions, stage 2 selects the output symbol and
// tracks running disparity.
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int unsigned LaneIdx = 0,
  parameter int unsigned CntW    = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [2:0]      mode_i,
  input  logic [7:0]      data_i,
  input  logic [1:0]      ctrl_i,
  input  logic [3:0]      aux_i,
  output logic [9:0]      tmds_o,
  output logic [CntW-1:0] disp_o
);

  localparam logic signed [CntW-1:0] Zero = '0;
  localparam logic signed [CntW-1:0] Two  = CntW'(2);

  logic [8:0] qm_d, qm_q;
  logic [3:0] n1_d, n1_q;
  logic [2:0] mode_q;
  logic [1:0] ctrl_q;
  logic [3:0] aux_q;

  always_comb begin
    qm_d = tm_minimise(data_i);
    n1_d = popcount8(qm_d[7:0]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      qm_q   <= '0;
      n1_q   <= '0;
      mode_q <= MODE_CTRL;
      ctrl_q <= 2'b00;
      aux_q  <= '0;
    end else begin
      qm_q   <= qm_d;
      n1_q   <= n1_d;
      mode_q <= mode_i;
      ctrl_q <= ctrl_i;
      aux_q  <= aux_i;
    end
  end

  logic signed [CntW-1:0] cnt_d, cnt_q;
  logic signed [CntW-1:0] n1s, n0s;
  logic [9:0]             sym_d, sym_q;
  logic                   q8;

  always_comb begin
    q8    = qm_q[8];
    n1s   = $signed(CntW'(n1_q));
    n0s   = $signed(CntW'(4'd8 - n1_q));
    sym_d = ctrl_sym(ctrl_q);
    cnt_d = Zero;
    case (mode_q)
      MODE_VIDEO: begin
        if ((cnt_q == Zero) || (n1_q == 4'd4)) begin
          sym_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = q8 ? (cnt_q + n1s - n0s) : (cnt_q + n0s - n1s);
        end else if (((cnt_q > Zero) && (n1_q > 4'd4)) || ((cnt_q < Zero) && (n1_q < 4'd4))) begin
          sym_d = {1'b1, q8, ~qm_q[7:0]};
          cnt_d = cnt_q + n0s - n1s + (q8 ? Two : Zero);
        end else begin
          sym_d = {1'b0, q8, qm_q[7:0]};
          cnt_d = cnt_q + n1s - n0s - (q8 ? Zero : Two);
        end
      end
      MODE_VGUARD: sym_d = (LaneIdx == 1) ? GUARD_SYM_B : GUARD_SYM_A;
      MODE_TERC4:  sym_d = terc4_sym(aux_q);
      MODE_DGUARD: sym_d = (LaneIdx == 0) ? terc4_sym(aux_q) : GUARD_SYM_B;
      default:     sym_d = ctrl_sym(ctrl_q);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sym_q <= '0;
      cnt_q <= Zero;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign tmds_o = sym_q;
  assign disp_o = cnt_q;

endmodule

// File: rtl/tmds_encoder_hdmi.sv
// HDMI TMDS encoder: NUM_CH lanes encoded in lockstep under a shared mode, two-cycle latency.
module tmds_encoder_hdmi
  import tmds_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [2:0]              mode_in,
  input  logic [NUM_CH*8-1:0]     data_in,
  input  logic [NUM_CH*2-1:0]     ctrl_in,
  input  logic [NUM_CH*4-1:0]     aux_in,
  output logic [NUM_CH*10-1:0]    tmds_out,
  output logic [NUM_CH*CNT_W-1:0] disp_out
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    tmds_lane #(
      .LaneIdx(c),
      .CntW   (CNT_W)
    ) u_lane (
      .clk_i (clk_in),
      .rst_i (rst_in),
      .mode_i(mode_in),
      .data_i(data_in[8*c +: 8]),
      .ctrl_i(ctrl_in[2*c +: 2]),
      .aux_i (aux_in[4*c +: 4]),
      .tmds_o(tmds_out[10*c +: 10]),
      .disp_o(disp_out[CNT_W*c +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_hdmi.sv
// Bench for tmds_encoder_hdmi: hand-derived vector table, then randomized traffic
// checked against an arithmetic reference model with a two-deep expectation queue.
module tb_tmds_encoder_hdmi;

  localparam int NumCh = 3;
  localparam int CntW  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  mode = 3'd0;
  logic [23:0] data = '0;
  logic [5:0]  ctrl = '0;
  logic [11:0] aux  = '0;
  logic [29:0] tmds;
  logic [14:0] disp;

  tmds_encoder_hdmi #(
    .NUM_CH(NumCh),
    .CNT_W (CntW)
  ) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .mode_in (mode),
    .data_in (data),
    .ctrl_in (ctrl),
    .aux_in  (aux),
    .tmds_out(tmds),
    .disp_out(disp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic [3:0]  aux;
    logic [29:0] exp_sym;
    int          exp_disp;
  } vec_t;

  typedef struct {
    logic [29:0] sym;
    logic [14:0] disp;
  } exp_t;

  localparam int NumVec = 14;
  vec_t        tbl[NumVec];
  logic [9:0]  terc4_ref[16];
  exp_t        expq[$];
  int          mcnt[NumCh];

  task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: the encoding rules written out with integer arithmetic.
  function automatic logic [9:0] model_sym(input int lane, input logic [2:0] m,
                                           input logic [7:0] d, input logic [1:0] c,
                                           input logic [3:0] a);
    logic [9:0] s;
    logic [7:0] q;
    logic       q8;
    int         n1, ones, zeros;
    case (m)
      3'd1: begin
        n1   = $countones(d);
        q8   = !((n1 > 4) || (n1 == 4 && d[0] == 1'b0));
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = q8 ? (q[i-1] ^ d[i]) : !(q[i-1] ^ d[i]);
        ones  = $countones(q);
        zeros = 8 - ones;
        if (mcnt[lane] == 0 || ones == zeros) begin
          s = {!q8, q8, q8 ? q : ~q};
          mcnt[lane] += q8 ? (ones - zeros) : (zeros - ones);
        end else if ((mcnt[lane] > 0 && ones > zeros) || (mcnt[lane] < 0 && zeros > ones)) begin
          s = {1'b1, q8, ~q};
          mcnt[lane] += 2 * int'(q8) + zeros - ones;
        end else begin
          s = {1'b0, q8, q};
          mcnt[lane] += -2 * int'(!q8) + ones - zeros;
        end
        return s;
      end
      3'd2:    s = (lane == 1) ? 10'b0100110011 : 10'b1011001100;
      3'd3:    s = terc4_ref[a];
      3'd4:    s = (lane == 0) ? terc4_ref[a] : 10'b0100110011;
      default: begin
        case (c)
          2'd0:    s = 10'b1101010100;
          2'd1:    s = 10'b0010101011;
          2'd2:    s = 10'b0101010100;
          default: s = 10'b1010101011;
        endcase
      end
    endcase
    mcnt[lane] = 0;
    return s;
  endfunction

  // After a reset the pipeline holds CTRL/00 for one symbol ahead of new input.
  task automatic model_reset();
    exp_t e;
    expq.delete();
    for (int l = 0; l < NumCh; l++) mcnt[l] = 0;
    e.sym  = {3{10'b1101010100}};
    e.disp = '0;
    expq.push_back(e);
  endtask

  task automatic step(input bit r, input logic [2:0] m, input logic [23:0] d,
                      input logic [5:0] c, input logic [11:0] a, input string name);
    exp_t e;
    rst = r; mode = m; data = d; ctrl = c; aux = a;
    if (!r) begin
      for (int l = 0; l < NumCh; l++) begin
        e.sym[10*l +: 10]   = model_sym(l, m, d[8*l +: 8], c[2*l +: 2], a[4*l +: 4]);
        e.disp[CntW*l +: CntW] = CntW'(mcnt[l]);
      end
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      check({name, " reset tmds"}, tmds, '0);
      check({name, " reset disp"}, {15'b0, disp}, '0);
      model_reset();
    end else begin
      e = expq.pop_front();
      check({name, " tmds"}, tmds, e.sym);
      check({name, " disp"}, {15'b0, disp}, {15'b0, e.disp});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    terc4_ref = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};

    tbl[0]  = '{3'd1, 8'hFF, 2'd0, 4'h0, {3{10'h200}}, -8};
    tbl[1]  = '{3'd1, 8'hFF, 2'd0, 4'h0, {3{10'h0FF}}, -2};
    tbl[2]  = '{3'd1, 8'hFF, 2'd0, 4'h0, {3{10'h0FF}}, 4};
    tbl[3]  = '{3'd0, 8'hFF, 2'd2, 4'h0, {3{10'b0101010100}}, 0};
    tbl[4]  = '{3'd1, 8'hFF, 2'd0, 4'h0, {3{10'h200}}, -8};
    tbl[5]  = '{3'd0, 8'h00, 2'd1, 4'h0, {3{10'b0010101011}}, 0};
    tbl[6]  = '{3'd0, 8'h00, 2'd3, 4'h0, {3{10'b1010101011}}, 0};
    tbl[7]  = '{3'd2, 8'h00, 2'd0, 4'h0, {10'b1011001100, 10'b0100110011, 10'b1011001100}, 0};
    tbl[8]  = '{3'd2, 8'h5A, 2'd0, 4'h0, {10'b1011001100, 10'b0100110011, 10'b1011001100}, 0};
    tbl[9]  = '{3'd4, 8'h00, 2'd0, 4'hC, {10'b0100110011, 10'b0100110011, 10'b1010001110}, 0};
    tbl[10] = '{3'd5, 8'h00, 2'd1, 4'h0, {3{10'b0010101011}}, 0};
    tbl[11] = '{3'd1, 8'h00, 2'd0, 4'h0, {3{10'h100}}, -8};
    tbl[12] = '{3'd1, 8'h00, 2'd0, 4'h0, {3{10'h3FF}}, 2};
    tbl[13] = '{3'd3, 8'h00, 2'd0, 4'h5, {3{10'b0100011110}}, 0};

    repeat (3) step(1'b1, 3'd0, '0, '0, '0, "por");

    // Release with the first table vector; the reset CTRL/00 symbol appears first.
    rst = 1'b0; mode = tbl[0].mode; data = {3{tbl[0].data}};
    ctrl = {3{tbl[0].ctrl}}; aux = {3{tbl[0].aux}};
    @(posedge clk);
    #1;
    check("release tmds", tmds, {3{10'b1101010100}});
    check("release disp", {15'b0, disp}, '0);

    for (int i = 1; i <= NumVec; i++) begin
      logic [4:0] dexp;
      if (i < NumVec) begin
        mode = tbl[i].mode; data = {3{tbl[i].data}};
        ctrl = {3{tbl[i].ctrl}}; aux = {3{tbl[i].aux}};
      end else begin
        mode = 3'd0; data = '0; ctrl = '0; aux = '0;
      end
      @(posedge clk);
      #1;
      dexp = 5'(tbl[i-1].exp_disp);
      check($sformatf("table[%0d] tmds", i-1), tmds, tbl[i-1].exp_sym);
      check($sformatf("table[%0d] disp", i-1), {15'b0, disp}, {15'b0, {3{dexp}}});
    end

    // Mid-stream reset after guard bands and video: no stale symbol may survive.
    step(1'b1, 3'd0, '0, '0, '0, "sync");
    step(1'b0, 3'd2, 24'h123456, '0, '0, "vguard0");
    step(1'b0, 3'd2, 24'h123456, '0, '0, "vguard1");
    step(1'b0, 3'd1, 24'hF0E1D2, '0, '0, "video0");
    step(1'b0, 3'd1, 24'h0F1E2D, '0, '0, "video1");
    step(1'b1, 3'd1, 24'hAAAAAA, '0, '0, "midrst");
    step(1'b0, 3'd1, 24'h334455, '0, '0, "post_rst");
    step(1'b0, 3'd1, 24'h000000, '0, '0, "post_rst1");

    for (int a = 0; a < 16; a++) begin
      logic [3:0] nib;
      nib = 4'(a);
      step(1'b0, 3'd3, 24'($urandom), 6'($urandom), {3{nib}}, "terc4");
    end
    step(1'b0, 3'd4, '0, '0, 12'h35C, "dguard");

    repeat (600) begin
      bit         r;
      logic [2:0] m;
      r = ($urandom_range(0, 63) == 0);
      m = ($urandom_range(0, 2) != 0) ? 3'd1 : 3'($urandom_range(0, 7));
      step(r, m, 24'($urandom), 6'($urandom), 12'($urandom), "rand");
    end
    repeat (2) step(1'b0, 3'd0, '0, '0, '0, "drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
